// File: rtl/lcd_pkg.sv
// Shared constants and types for the LCD 1602A frame sequencer.
//   Command indices understood by the controller, pad character,
//   DDRAM geometry, refresh phase and sequencer state encodings.
package lcd_pkg;

  localparam logic [5:0] CMD_NONE  = 6'd0;
  localparam logic [5:0] CMD_INIT  = 6'd1;
  localparam logic [5:0] CMD_SEND  = 6'd3;
  localparam logic [5:0] CMD_CLEAR = 6'd4;

  localparam logic [7:0] PAD_CHAR = 8'h20;

  localparam int unsigned CHARS_PER_LINE = 16;
  localparam int unsigned LINE1_SPAN     = 40;
  localparam logic [7:0]  LINE2_BASE     = 8'h40;

  typedef enum logic [1:0] {
    PH_INIT,
    PH_CLEAR,
    PH_DATA
  } phase_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_DONE,
    ST_GAP,
    ST_FAIL
  } state_t;

  function automatic logic [5:0] phase_cmd(input phase_t ph);
    case (ph)
      PH_INIT:  return CMD_INIT;
      PH_CLEAR: return CMD_CLEAR;
      default:  return CMD_SEND;
    endcase
  endfunction

endpackage

// File: rtl/lcd_frame_buffer.sv
// Host-written character frame buffer.
//   clk     : clock
//   wr_en   : synchronous write strobe
//   wr_addr : write index (0..DEPTH-1)
//   wr_data : character written
//   rd_addr : read index
//   rd_data : combinational read of mem[rd_addr]
module lcd_frame_buffer import lcd_pkg::*; #(
  parameter int unsigned DEPTH = 2 * CHARS_PER_LINE,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/lcd_frame_sequencer.sv
// Refreshes a 2x16 LCD 1602A from a 32-byte host frame buffer through the
// controller's command/handshake port. Each refresh issues INIT (first
// refresh after reset only), CLEAR, then 56 SEND_DATA writes: 16 line-1
// characters, 24 pad characters walking DDRAM to line 2, 16 line-2 characters.
//   clk, rst   : clock, synchronous active-high reset
//   wr_en/wr_addr/wr_data : host buffer write port (0-15 line 1, 16-31 line 2)
//   refresh    : single-cycle refresh request (one-deep pending while busy)
//   busy       : refresh in progress
//   done       : one-cycle pulse on completion
//   error      : sticky handshake timeout flag
//   lcd_cmd/lcd_enable/lcd_data/lcd_rdy : controller handshake port
module lcd_frame_sequencer #(
  parameter int unsigned CHARS_PER_LINE = 16,
  parameter int unsigned LINE1_SPAN     = 40,
  parameter logic [7:0]  PAD_CHAR       = 8'h20,
  parameter int unsigned ACK_TIMEOUT    = 16,
  parameter int unsigned DONE_CNT_W     = 22
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [4:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       refresh,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [5:0] lcd_cmd,
  output logic       lcd_enable,
  output logic [7:0] lcd_data,
  input  logic       lcd_rdy
);
  import lcd_pkg::*;

  localparam int unsigned N_DATA = LINE1_SPAN + CHARS_PER_LINE;
  localparam int unsigned POS_W  = $clog2(N_DATA);
  localparam int unsigned AW     = $clog2(2 * CHARS_PER_LINE);
  localparam int unsigned ACK_W  = $clog2(ACK_TIMEOUT + 1);

  localparam logic [POS_W-1:0] POS_LAST = POS_W'(N_DATA - 1);
  localparam logic [POS_W-1:0] POS_PAD  = POS_W'(CHARS_PER_LINE);
  localparam logic [POS_W-1:0] POS_L2   = POS_W'(LINE1_SPAN);
  localparam logic [POS_W-1:0] L2_OFS   = POS_W'(LINE1_SPAN - CHARS_PER_LINE);
  localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_TIMEOUT);

  state_t                state, state_n;
  phase_t                phase, phase_n;
  logic [POS_W-1:0]      pos, pos_n;
  logic                  init_done, init_done_n;
  logic                  pending, pending_n;
  logic                  busy_n, done_n, error_n;
  logic [ACK_W-1:0]      ack_cnt, ack_cnt_n;
  logic [DONE_CNT_W-1:0] wd_cnt, wd_cnt_n;
  logic                  load_data;
  logic [AW-1:0]         rd_addr;
  logic [7:0]            rd_data;
  logic [7:0]            next_char;

  lcd_frame_buffer #(
    .DEPTH(2 * CHARS_PER_LINE)
  ) u_buf (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // The character is picked for the position about to be issued, so it is
  // looked up from the next phase/pos rather than the current ones.
  always_comb begin
    rd_addr = '0;
    if (pos_n < POS_PAD) rd_addr = AW'(pos_n);
    else if (pos_n >= POS_L2) rd_addr = AW'(pos_n - L2_OFS);
  end

  always_comb begin
    next_char = PAD_CHAR;
    if (phase_n == PH_DATA && (pos_n < POS_PAD || pos_n >= POS_L2))
      next_char = rd_data;
  end

  always_comb begin
    state_n     = state;
    phase_n     = phase;
    pos_n       = pos;
    init_done_n = init_done;
    pending_n   = pending;
    busy_n      = busy;
    done_n      = 1'b0;
    error_n     = error;
    ack_cnt_n   = ack_cnt;
    wd_cnt_n    = wd_cnt;
    load_data   = 1'b0;

    if (refresh && busy) pending_n = 1'b1;

    unique case (state)
      ST_IDLE: begin
        if (error) begin
          pending_n = 1'b0;
        end else if (done) begin
          // A request coinciding with done waits one IDLE cycle.
          pending_n = pending | refresh;
        end else if (refresh || pending) begin
          busy_n    = 1'b1;
          pending_n = 1'b0;
          phase_n   = init_done ? PH_CLEAR : PH_INIT;
          ack_cnt_n = '0;
          load_data = 1'b1;
          state_n   = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        // rdy is still high from idle in the first cycle, so it is ignored there.
        if (ack_cnt != '0 && !lcd_rdy) begin
          wd_cnt_n = '0;
          state_n  = ST_WAIT_DONE;
        end else if (ack_cnt == ACK_LAST) begin
          error_n   = 1'b1;
          busy_n    = 1'b0;
          pending_n = 1'b0;
          state_n   = ST_FAIL;
        end else begin
          ack_cnt_n = ack_cnt + 1'b1;
        end
      end

      ST_WAIT_DONE: begin
        if (lcd_rdy) begin
          state_n = ST_GAP;
        end else if (&wd_cnt) begin
          error_n   = 1'b1;
          busy_n    = 1'b0;
          pending_n = 1'b0;
          state_n   = ST_FAIL;
        end else begin
          wd_cnt_n = wd_cnt + 1'b1;
        end
      end

      ST_GAP: begin
        ack_cnt_n = '0;
        load_data = 1'b1;
        state_n   = ST_ISSUE;
        case (phase)
          PH_INIT: begin
            init_done_n = 1'b1;
            phase_n     = PH_CLEAR;
          end
          PH_CLEAR: begin
            phase_n = PH_DATA;
            pos_n   = '0;
          end
          default: begin
            if (pos == POS_LAST) begin
              done_n    = 1'b1;
              busy_n    = 1'b0;
              load_data = 1'b0;
              state_n   = ST_IDLE;
            end else begin
              pos_n = pos + 1'b1;
            end
          end
        endcase
      end

      ST_FAIL: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      phase     <= PH_INIT;
      pos       <= '0;
      init_done <= 1'b0;
      pending   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      ack_cnt   <= '0;
      wd_cnt    <= '0;
      lcd_data  <= PAD_CHAR;
    end else begin
      state     <= state_n;
      phase     <= phase_n;
      pos       <= pos_n;
      init_done <= init_done_n;
      pending   <= pending_n;
      busy      <= busy_n;
      done      <= done_n;
      error     <= error_n;
      ack_cnt   <= ack_cnt_n;
      wd_cnt    <= wd_cnt_n;
      if (load_data) lcd_data <= next_char;
    end
  end

  assign lcd_enable = (state == ST_ISSUE) || (state == ST_WAIT_DONE);
  assign lcd_cmd    = lcd_enable ? phase_cmd(phase) : CMD_NONE;

endmodule
